mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit_if.sv | 14 +
 rtl/mult_div_unit.sv | 130 +++++++++++++
 tb/tb_mult_div_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between the issue stage and the HI/LO unit
interface mult_div_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs;
  logic [XLEN-1:0] rt;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output start, op, rs, rt, input busy, done, hi, lo);
  modport slave  (input start, op, rs, rt, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MIPS HI/LO unit: shift-add multiply, restoring divide, MTHI/MTLO
module mult_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [1:0]        op_r;
  logic              sa, sb;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic              busy_q, done_q;

  logic              rs_neg, rt_neg;
  logic [XLEN-1:0]   rs_abs, rt_abs;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic              is_signed;
  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0]   quo_f, rem_f;

  // op[0]=0 selects the signed flavour of MULT/DIV
  always_comb begin
    rs_neg = ~bus.op[0] & bus.rs[XLEN-1];
    rt_neg = ~bus.op[0] & bus.rt[XLEN-1];
    rs_abs = rs_neg ? -bus.rs : bus.rs;
    rt_abs = rt_neg ? -bus.rt : bus.rt;
  end

  // multiply: acc = {partial product, remaining multiplier bits}, LSB examined each step
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
  end

  // divide: acc = {partial remainder, dividend/quotient}, shifted left one bit per step
  always_comb begin
    div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    div_next = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  // with a zero divisor the restoring loop leaves rem=|rs|, so hi comes back as rs; only lo is forced
  always_comb begin
    is_signed = ~op_r[0];
    prod_f    = (is_signed && (sa ^ sb)) ? -acc : acc;
    quo_f     = (is_signed && (sa ^ sb)) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_f     = (is_signed && sa) ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (opnd == '0) quo_f = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_r   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                op_r   <= bus.op[1:0];
                sa     <= rs_neg;
                sb     <= rt_neg;
                cnt    <= '0;
                opnd   <= bus.op[1] ? rt_abs : rs_abs;
                acc    <= {{XLEN{1'b0}}, (bus.op[1] ? rs_abs : rt_abs)};
                busy_q <= 1'b1;
                state  <= RUN;
              end
              3'b100: begin
                hi_q   <= bus.rs;
                done_q <= 1'b1;
              end
              3'b101: begin
                lo_q   <= bus.rs;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          acc <= op_r[1] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (&cnt) state <= FIX;
        end
        FIX: begin
          if (op_r[1]) begin
            hi_q <= rem_f;
            lo_q <= quo_f;
          end else begin
            hi_q <= prod_f[2*XLEN-1:XLEN];
            lo_q <= prod_f[XLEN-1:0];
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      3'd0: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
      3'd1: begin up = {32'b0, a} * {32'b0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
      3'd2: begin
        if (b == 0) begin m_hi = a; m_lo = 32'hFFFFFFFF; end
        else begin sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      end
      3'd3: begin
        if (b == 0) begin m_hi = a; m_lo = 32'hFFFFFFFF; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs = a; bus.rt = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.rs = $urandom; bus.rt = $urandom;
    if (o <= 3'd3) begin
      check("busy_rise", bus.busy, 1);
      check("done_early", bus.done, 0);
      cyc = 1;
      while (bus.busy === 1'b1 && cyc < 60) begin
        if (poke && cyc == 5) begin
          bus.start = 1'b1; bus.op = 3'b100; bus.rs = 32'hDEADBEEF;
        end else begin
          bus.start = 1'b0;
        end
        if (cyc == 16) begin
          check("hi_hold", bus.hi, m_hi);
          check("lo_hold", bus.lo, m_lo);
          check("done_mid", bus.done, 0);
        end
        @(posedge clk); #1;
        cyc++;
      end
      bus.start = 1'b0;
      check("latency", cyc - 1, 33);
      model(o, a, b);
      check("done_pulse", bus.done, 1);
    end else begin
      model(o, a, b);
      check("busy_mt", bus.busy, 0);
      check("done_mt", bus.done, (o == 3'd4 || o == 3'd5));
    end
    check("hi", bus.hi, m_hi);
    check("lo", bus.lo, m_lo);
    @(posedge clk); #1;
    check("done_clear", bus.done, 0);
    check("busy_idle", bus.busy, 0);
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.op = 3'b0; bus.rs = '0; bus.rt = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(3'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
    run_op(3'd0, 32'h80000000, 32'h80000000, 1'b0);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_op(3'd3, 32'd100, 32'd7, 1'b0);
    run_op(3'd3, 32'h10, 32'd0, 1'b0);
    run_op(3'd2, 32'hFFFFFFF3, 32'd0, 1'b0);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(3'd4, 32'hA5A5A5A5, 32'd0, 1'b0);
    run_op(3'd5, 32'h5A5A5A5A, 32'd0, 1'b0);
    run_op(3'd6, 32'h12345678, 32'd0, 1'b0);
    run_op(3'd1, 32'h0001_0003, 32'h0002_0005, 1'b1);

    repeat (30) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      run_op(o, a, b, ($urandom_range(0, 3) == 0));
    end

    // abort a DIV partway through with an asynchronous reset
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.rs = 32'hFFFF0000; bus.rt = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("busy_before_rst", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd1, 32'd3, 32'd5, 1'b0);
    check("post_rst_lo15", bus.lo, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
